// File: rtl/ps2_key_pkg.sv
// Shared types, scan-code constants and the set-2 to ASCII translation table
// for the PS/2 keyboard decoder.
package ps2_key_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK,
        ST_PAUSE
    } state_t;

    typedef struct packed {
        logic       hit;
        logic [7:0] ch;
    } xlat_t;

    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SC_PAUSE  = 8'hE1;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CTRL   = 8'h14;
    localparam logic [7:0] SC_CAPS   = 8'h58;

    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    // Returns {is_letter, lower-case ASCII}.
    function automatic logic [8:0] letter_lower(input logic [7:0] sc);
        logic [8:0] r;
        r = 9'h000;
        case (sc)
            8'h1C: r = {1'b1, 8'h61};
            8'h32: r = {1'b1, 8'h62};
            8'h21: r = {1'b1, 8'h63};
            8'h23: r = {1'b1, 8'h64};
            8'h24: r = {1'b1, 8'h65};
            8'h2B: r = {1'b1, 8'h66};
            8'h34: r = {1'b1, 8'h67};
            8'h33: r = {1'b1, 8'h68};
            8'h43: r = {1'b1, 8'h69};
            8'h3B: r = {1'b1, 8'h6A};
            8'h42: r = {1'b1, 8'h6B};
            8'h4B: r = {1'b1, 8'h6C};
            8'h3A: r = {1'b1, 8'h6D};
            8'h31: r = {1'b1, 8'h6E};
            8'h44: r = {1'b1, 8'h6F};
            8'h4D: r = {1'b1, 8'h70};
            8'h15: r = {1'b1, 8'h71};
            8'h2D: r = {1'b1, 8'h72};
            8'h1B: r = {1'b1, 8'h73};
            8'h2C: r = {1'b1, 8'h74};
            8'h3C: r = {1'b1, 8'h75};
            8'h2A: r = {1'b1, 8'h76};
            8'h1D: r = {1'b1, 8'h77};
            8'h22: r = {1'b1, 8'h78};
            8'h35: r = {1'b1, 8'h79};
            8'h1A: r = {1'b1, 8'h7A};
            default: r = 9'h000;
        endcase
        return r;
    endfunction

    // Non-letter keys: returns {hit, unshifted, shifted} on the US layout.
    function automatic logic [16:0] plain_keys(input logic [7:0] sc);
        logic [16:0] r;
        r = 17'h00000;
        case (sc)
            8'h16: r = {1'b1, 8'h31, 8'h21};
            8'h1E: r = {1'b1, 8'h32, 8'h40};
            8'h26: r = {1'b1, 8'h33, 8'h23};
            8'h25: r = {1'b1, 8'h34, 8'h24};
            8'h2E: r = {1'b1, 8'h35, 8'h25};
            8'h36: r = {1'b1, 8'h36, 8'h5E};
            8'h3D: r = {1'b1, 8'h37, 8'h26};
            8'h3E: r = {1'b1, 8'h38, 8'h2A};
            8'h46: r = {1'b1, 8'h39, 8'h28};
            8'h45: r = {1'b1, 8'h30, 8'h29};
            8'h0E: r = {1'b1, 8'h60, 8'h7E};
            8'h4E: r = {1'b1, 8'h2D, 8'h5F};
            8'h55: r = {1'b1, 8'h3D, 8'h2B};
            8'h54: r = {1'b1, 8'h5B, 8'h7B};
            8'h5B: r = {1'b1, 8'h5D, 8'h7D};
            8'h5D: r = {1'b1, 8'h5C, 8'h7C};
            8'h4C: r = {1'b1, 8'h3B, 8'h3A};
            8'h52: r = {1'b1, 8'h27, 8'h22};
            8'h41: r = {1'b1, 8'h2C, 8'h3C};
            8'h49: r = {1'b1, 8'h2E, 8'h3E};
            8'h4A: r = {1'b1, 8'h2F, 8'h3F};
            8'h66: r = {1'b1, 8'h7F, 8'h7F};
            8'h0D: r = {1'b1, 8'h09, 8'h09};
            8'h29: r = {1'b1, 8'h20, 8'h20};
            8'h5A: r = {1'b1, 8'h0A, 8'h0A};
            8'h76: r = {1'b1, 8'h1B, 8'h1B};
            8'h70: r = {1'b1, 8'h30, 8'h30};
            8'h69: r = {1'b1, 8'h31, 8'h31};
            8'h72: r = {1'b1, 8'h32, 8'h32};
            8'h7A: r = {1'b1, 8'h33, 8'h33};
            8'h6B: r = {1'b1, 8'h34, 8'h34};
            8'h73: r = {1'b1, 8'h35, 8'h35};
            8'h74: r = {1'b1, 8'h36, 8'h36};
            8'h6C: r = {1'b1, 8'h37, 8'h37};
            8'h75: r = {1'b1, 8'h38, 8'h38};
            8'h7D: r = {1'b1, 8'h39, 8'h39};
            8'h71: r = {1'b1, 8'h2E, 8'h2E};
            8'h7C: r = {1'b1, 8'h2A, 8'h2A};
            8'h7B: r = {1'b1, 8'h2D, 8'h2D};
            8'h79: r = {1'b1, 8'h2B, 8'h2B};
            default: r = 17'h00000;
        endcase
        return r;
    endfunction

    // Modifier make codes are intercepted by the caller before this is consulted.
    function automatic xlat_t translate(input logic       ext,
                                        input logic [7:0] sc,
                                        input logic       shift,
                                        input logic       caps,
                                        input logic       ctrl,
                                        input logic [7:0] unknown);
        xlat_t       r;
        logic [8:0]  lt;
        logic [16:0] pk;
        r  = '0;
        lt = letter_lower(sc);
        pk = plain_keys(sc);
        if (ext) begin
            r.hit = 1'b1;
            case (sc)
                8'h4A:   r.ch = 8'h2F;
                8'h5A:   r.ch = 8'h0A;
                8'h71:   r.ch = 8'h7F;
                default: r.hit = 1'b0;
            endcase
        end else if (lt[8]) begin
            r.hit = 1'b1;
            if (ctrl)
                r.ch = lt[7:0] & 8'h1F;
            else if (shift ^ caps)
                r.ch = lt[7:0] - 8'h20;
            else
                r.ch = lt[7:0];
        end else if (pk[16]) begin
            r.hit = 1'b1;
            r.ch  = shift ? pk[7:0] : pk[15:8];
        end else begin
            r.hit = 1'b1;
            r.ch  = unknown;
        end
        return r;
    endfunction

endpackage

// File: rtl/ps2_key_decoder_char_fifo.sv
// Small synchronous FIFO for character streams; power-of-two depth so the
// pointers wrap on their own.
module char_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop & ~o_empty;
    // A push into a full FIFO is only accepted when the head leaves in the same cycle.
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++)
                r_mem[i] <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 scan-code to ASCII decoder: prefix FSM (E0/F0/E1), Shift/Ctrl/Caps
// tracking and a buffered valid/ready character output with overflow flag.
module ps2_key_decoder
    import ps2_key_pkg::*;
#(
    parameter int         FIFO_DEPTH   = 4,
    parameter bit         ENABLE_CTRL  = 1'b1,
    parameter bit         ENABLE_CAPS  = 1'b1,
    parameter logic [7:0] UNKNOWN_CHAR = 8'h2E
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] scan,
    input  logic       scanrdy,
    output logic [7:0] ascii,
    output logic       ascii_valid,
    input  logic       ascii_ready,
    output logic       overflow,
    output logic       caps_lock,
    output logic [2:0] mods
);
    logic [1:0] r_history;
    state_t     r_state, w_state_nx;
    logic [2:0] r_skip, w_skip_nx;
    logic       r_lshift, w_lshift_nx;
    logic       r_rshift, w_rshift_nx;
    logic       r_lctrl, w_lctrl_nx;
    logic       r_rctrl, w_rctrl_nx;
    logic       r_caps, w_caps_nx;
    logic       r_caps_held, w_caps_held_nx;
    logic       r_overflow;

    logic       w_event;
    logic       w_shift;
    logic       w_ctrl;
    logic       w_push;
    logic [7:0] w_push_char;
    logic       w_pop;
    logic       w_full;
    logic       w_empty;
    xlat_t      w_xlat;

    assign w_event = (r_history == 2'b10);
    assign w_shift = r_lshift | r_rshift;
    assign w_ctrl  = r_lctrl | r_rctrl;
    assign w_xlat  = translate(r_state == ST_EXT, scan, w_shift, r_caps, w_ctrl, UNKNOWN_CHAR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_history   <= 2'b00;
            r_state     <= ST_IDLE;
            r_skip      <= '0;
            r_lshift    <= 1'b0;
            r_rshift    <= 1'b0;
            r_lctrl     <= 1'b0;
            r_rctrl     <= 1'b0;
            r_caps      <= 1'b0;
            r_caps_held <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_history   <= {r_history[0], scanrdy};
            r_state     <= w_state_nx;
            r_skip      <= w_skip_nx;
            r_lshift    <= w_lshift_nx;
            r_rshift    <= w_rshift_nx;
            r_lctrl     <= w_lctrl_nx;
            r_rctrl     <= w_rctrl_nx;
            r_caps      <= w_caps_nx;
            r_caps_held <= w_caps_held_nx;
            r_overflow  <= r_overflow | (w_push & w_full & ~w_pop);
        end
    end

    always_comb begin
        w_state_nx     = r_state;
        w_skip_nx      = r_skip;
        w_lshift_nx    = r_lshift;
        w_rshift_nx    = r_rshift;
        w_lctrl_nx     = r_lctrl;
        w_rctrl_nx     = r_rctrl;
        w_caps_nx      = r_caps;
        w_caps_held_nx = r_caps_held;
        w_push         = 1'b0;
        w_push_char    = w_xlat.ch;
        if (w_event) begin
            case (r_state)
                ST_IDLE: begin
                    if (scan == SC_EXT) begin
                        w_state_nx = ST_EXT;
                    end else if (scan == SC_BRK) begin
                        w_state_nx = ST_BRK;
                    end else if (scan == SC_PAUSE) begin
                        w_state_nx = ST_PAUSE;
                        w_skip_nx  = PAUSE_SKIP;
                    end else if (scan == SC_LSHIFT) begin
                        w_lshift_nx = 1'b1;
                    end else if (scan == SC_RSHIFT) begin
                        w_rshift_nx = 1'b1;
                    end else if (scan == SC_CTRL) begin
                        w_lctrl_nx = ENABLE_CTRL;
                    end else if (scan == SC_CAPS) begin
                        // Typematic repeats of Caps must not keep flipping the lock.
                        if (ENABLE_CAPS) begin
                            w_caps_nx      = r_caps ^ ~r_caps_held;
                            w_caps_held_nx = 1'b1;
                        end
                    end else begin
                        w_push = w_xlat.hit;
                    end
                end
                ST_EXT: begin
                    if (scan == SC_BRK) begin
                        w_state_nx = ST_EXT_BRK;
                    end else if (scan != SC_EXT) begin
                        w_state_nx = ST_IDLE;
                        if (scan == SC_CTRL)
                            w_rctrl_nx = ENABLE_CTRL;
                        else
                            w_push = w_xlat.hit;
                    end
                end
                ST_BRK: begin
                    if (scan != SC_BRK) begin
                        w_state_nx = ST_IDLE;
                        case (scan)
                            SC_LSHIFT: w_lshift_nx    = 1'b0;
                            SC_RSHIFT: w_rshift_nx    = 1'b0;
                            SC_CTRL:   w_lctrl_nx     = 1'b0;
                            SC_CAPS:   w_caps_held_nx = 1'b0;
                            default:   w_state_nx     = ST_IDLE;
                        endcase
                    end
                end
                ST_EXT_BRK: begin
                    w_state_nx = ST_IDLE;
                    if (scan == SC_CTRL)
                        w_rctrl_nx = 1'b0;
                end
                ST_PAUSE: begin
                    w_skip_nx = r_skip - 3'd1;
                    if (r_skip <= 3'd1)
                        w_state_nx = ST_IDLE;
                end
                default: w_state_nx = ST_IDLE;
            endcase
        end
    end

    char_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_push_char),
        .i_pop   (w_pop),
        .o_data  (ascii),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_pop       = ~w_empty & ascii_ready;
    assign ascii_valid = ~w_empty;
    assign overflow    = r_overflow;
    assign caps_lock   = r_caps;
    assign mods        = {w_ctrl, r_caps, w_shift};

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: vector table, directed corner
// sequences and a randomized keystroke stream checked against a layout model.
module tb_ps2_key_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] scan;
    logic       scanrdy;
    logic [7:0] ascii;
    logic       ascii_valid;
    logic       ascii_ready;
    logic       overflow;
    logic       caps_lock;
    logic [2:0] mods;

    int total = 0;
    int bad   = 0;
    bit randReady = 1'b0;

    logic [7:0] gotQ [$];
    logic [7:0] expQ [$];
    logic [7:0] poolQ [$];

    logic [7:0] baseMap  [256];
    logic [7:0] shiftMap [256];
    bit         known    [256];
    bit         letter   [256];

    bit mExt, mBrk, mL, mR, mLc, mRc, mCaps, mHeld;
    int mPause;

    typedef struct {
        int         n;
        logic [7:0] b0, b1, b2;
        int         expN;
        logic [7:0] expCh;
    } vec_t;
    vec_t vecs [16];

    always #5 clk = ~clk;

    ps2_key_decoder #(
        .FIFO_DEPTH   (4),
        .ENABLE_CTRL  (1'b1),
        .ENABLE_CAPS  (1'b1),
        .UNKNOWN_CHAR (8'h2E)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .scan        (scan),
        .scanrdy     (scanrdy),
        .ascii       (ascii),
        .ascii_valid (ascii_valid),
        .ascii_ready (ascii_ready),
        .overflow    (overflow),
        .caps_lock   (caps_lock),
        .mods        (mods)
    );

    // Every accepted handshake is recorded; the pop itself happens on the next rising edge.
    always @(negedge clk)
        if (!rst && ascii_valid && ascii_ready)
            gotQ.push_back(ascii);

    task automatic buildMaps();
        string      letters  = "abcdefghijklmnopqrstuvwxyz";
        string      digits   = "1234567890";
        string      digitsSh = "!@#$%^&*()";
        string      keypad   = "0123456789.*-+";
        logic [7:0] pv   [11] = '{8'h60, 8'h2D, 8'h3D, 8'h5B, 8'h5D, 8'h5C, 8'h3B, 8'h27, 8'h2C, 8'h2E, 8'h2F};
        logic [7:0] pvSh [11] = '{8'h7E, 8'h5F, 8'h2B, 8'h7B, 8'h7D, 8'h7C, 8'h3A, 8'h22, 8'h3C, 8'h3E, 8'h3F};
        logic [7:0] lc [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
        logic [7:0] dc [10] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46, 8'h45};
        logic [7:0] pc [11] = '{8'h0E, 8'h4E, 8'h55, 8'h54, 8'h5B, 8'h5D, 8'h4C, 8'h52, 8'h41, 8'h49, 8'h4A};
        logic [7:0] kc [14] = '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D,
                                8'h71, 8'h7C, 8'h7B, 8'h79};
        logic [7:0] sc [5]  = '{8'h66, 8'h0D, 8'h29, 8'h5A, 8'h76};
        logic [7:0] sv [5]  = '{8'h7F, 8'h09, 8'h20, 8'h0A, 8'h1B};
        logic [7:0] unk [5] = '{8'h05, 8'h06, 8'h11, 8'h77, 8'h7E};
        for (int i = 0; i < 256; i++) begin
            known[i] = 1'b0; letter[i] = 1'b0; baseMap[i] = 8'h00; shiftMap[i] = 8'h00;
        end
        for (int i = 0; i < 26; i++) begin
            known[lc[i]] = 1'b1; letter[lc[i]] = 1'b1;
            baseMap[lc[i]] = letters[i]; shiftMap[lc[i]] = letters[i] - 8'd32;
        end
        for (int i = 0; i < 10; i++) begin
            known[dc[i]] = 1'b1; baseMap[dc[i]] = digits[i]; shiftMap[dc[i]] = digitsSh[i];
        end
        for (int i = 0; i < 11; i++) begin
            known[pc[i]] = 1'b1; baseMap[pc[i]] = pv[i]; shiftMap[pc[i]] = pvSh[i];
        end
        for (int i = 0; i < 14; i++) begin
            known[kc[i]] = 1'b1; baseMap[kc[i]] = keypad[i]; shiftMap[kc[i]] = keypad[i];
        end
        for (int i = 0; i < 5; i++) begin
            known[sc[i]] = 1'b1; baseMap[sc[i]] = sv[i]; shiftMap[sc[i]] = sv[i];
        end
        for (int i = 0; i < 256; i++)
            if (known[i]) poolQ.push_back(8'(i));
        for (int i = 0; i < 5; i++)
            poolQ.push_back(unk[i]);
    endtask

    task automatic modelReset();
        mExt = 0; mBrk = 0; mL = 0; mR = 0; mLc = 0; mRc = 0; mCaps = 0; mHeld = 0; mPause = 0;
    endtask

    task automatic modelPress(input bit ext, input logic [7:0] b);
        logic [7:0] ch;
        if (ext) begin
            if (b == 8'h14) mRc = 1;
            else if (b == 8'h4A) expQ.push_back(8'h2F);
            else if (b == 8'h5A) expQ.push_back(8'h0A);
            else if (b == 8'h71) expQ.push_back(8'h7F);
        end else if (b == 8'h12) mL = 1;
        else if (b == 8'h59) mR = 1;
        else if (b == 8'h14) mLc = 1;
        else if (b == 8'h58) begin
            if (!mHeld) mCaps = !mCaps;
            mHeld = 1;
        end else begin
            if (!known[b])                   ch = 8'h2E;
            else if (letter[b] && (mLc|mRc)) ch = baseMap[b] & 8'h1F;
            else if (letter[b])              ch = ((mL|mR) ^ mCaps) ? shiftMap[b] : baseMap[b];
            else                             ch = (mL|mR) ? shiftMap[b] : baseMap[b];
            expQ.push_back(ch);
        end
    endtask

    task automatic modelRelease(input bit ext, input logic [7:0] b);
        if (ext) begin
            if (b == 8'h14) mRc = 0;
        end else begin
            if (b == 8'h12) mL = 0;
            if (b == 8'h59) mR = 0;
            if (b == 8'h14) mLc = 0;
            if (b == 8'h58) mHeld = 0;
        end
    endtask

    task automatic modelByte(input logic [7:0] b);
        if (mPause > 0) mPause--;
        else if (mBrk) begin
            if (!(b == 8'hF0 && !mExt)) begin
                modelRelease(mExt, b); mExt = 0; mBrk = 0;
            end
        end
        else if (b == 8'hF0) mBrk = 1;
        else if (b == 8'hE0) mExt = 1;
        else if (b == 8'hE1 && !mExt) mPause = 7;
        else begin
            modelPress(mExt, b); mExt = 0;
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        @(posedge clk); #1;
        scan    = b;
        scanrdy = 1'b1;
        if (randReady) ascii_ready = ($urandom_range(0, 1) == 1);
        repeat (2) @(posedge clk);
        #1 scanrdy = 1'b0;
        if (randReady) ascii_ready = 1'b1;
        repeat (3) @(posedge clk);
        modelByte(b);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic checkGot(input string name, input int n, input logic [7:0] e0 = 0,
                            input logic [7:0] e1 = 0, input logic [7:0] e2 = 0, input logic [7:0] e3 = 0);
        logic [7:0] e [4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        repeat (6) @(posedge clk);
        #1;
        checkOutput({name, " count"}, gotQ.size(), n);
        for (int i = 0; i < n; i++)
            checkOutput($sformatf("%s char%0d", name, i),
                        (i < gotQ.size()) ? {24'h0, gotQ[i]} : 32'hFFFF_FFFF, {24'h0, e[i]});
        gotQ.delete();
        expQ.delete();
    endtask

    task automatic doReset();
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        modelReset();
        gotQ.delete();
        expQ.delete();
    endtask

    task automatic sendSeq(input logic [7:0] s [$]);
        foreach (s[i]) applyStimulus(s[i]);
    endtask

    initial begin
        logic [7:0] code;
        int         r, m, n;
        buildMaps();
        modelReset();
        rst = 1'b1; scan = 8'h00; scanrdy = 1'b0; ascii_ready = 1'b1;
        #1;
        checkOutput("reset ascii", ascii, 8'h00);
        checkOutput("reset valid", ascii_valid, 1'b0);
        checkOutput("reset overflow", overflow, 1'b0);
        checkOutput("reset caps", caps_lock, 1'b0);
        checkOutput("reset mods", mods, 3'b000);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        vecs[0]  = '{3, 8'h1C, 8'hF0, 8'h1C, 1, 8'h61};
        vecs[1]  = '{2, 8'hE0, 8'h5A, 8'h00, 1, 8'h0A};
        vecs[2]  = '{2, 8'hE0, 8'h75, 8'h00, 0, 8'h00};
        vecs[3]  = '{2, 8'hE0, 8'h4A, 8'h00, 1, 8'h2F};
        vecs[4]  = '{2, 8'hE0, 8'h71, 8'h00, 1, 8'h7F};
        vecs[5]  = '{1, 8'h66, 8'h00, 8'h00, 1, 8'h7F};
        vecs[6]  = '{1, 8'h0D, 8'h00, 8'h00, 1, 8'h09};
        vecs[7]  = '{1, 8'h29, 8'h00, 8'h00, 1, 8'h20};
        vecs[8]  = '{1, 8'h76, 8'h00, 8'h00, 1, 8'h1B};
        vecs[9]  = '{1, 8'h7C, 8'h00, 8'h00, 1, 8'h2A};
        vecs[10] = '{1, 8'h79, 8'h00, 8'h00, 1, 8'h2B};
        vecs[11] = '{1, 8'h70, 8'h00, 8'h00, 1, 8'h30};
        vecs[12] = '{1, 8'h05, 8'h00, 8'h00, 1, 8'h2E};
        vecs[13] = '{3, 8'hE0, 8'hF0, 8'h75, 0, 8'h00};
        vecs[14] = '{1, 8'h4A, 8'h00, 8'h00, 1, 8'h2F};
        vecs[15] = '{1, 8'h16, 8'h00, 8'h00, 1, 8'h31};
        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i].b0);
            if (vecs[i].n > 1) applyStimulus(vecs[i].b1);
            if (vecs[i].n > 2) applyStimulus(vecs[i].b2);
            checkGot($sformatf("vec%0d", i), vecs[i].expN, vecs[i].expCh);
        end

        // Latency: valid must appear exactly on the second edge that sees scanrdy low.
        @(posedge clk); #1 ascii_ready = 1'b0; scan = 8'h1C; scanrdy = 1'b1;
        repeat (2) @(posedge clk);
        #1 scanrdy = 1'b0;
        @(posedge clk); #1;
        checkOutput("latency edge1 valid", ascii_valid, 1'b0);
        @(posedge clk); #1;
        checkOutput("latency edge2 valid", ascii_valid, 1'b1);
        checkOutput("latency edge2 ascii", ascii, 8'h61);
        repeat (2) @(posedge clk);
        modelByte(8'h1C);
        applyStimulus(8'hF0); applyStimulus(8'h1C);
        #1 ascii_ready = 1'b1;
        checkGot("single key", 1, 8'h61);

        doReset();
        sendSeq('{8'h12, 8'h1C, 8'hF0, 8'h1C, 8'hF0, 8'h12});
        checkGot("shift A", 1, 8'h41);
        sendSeq('{8'h58, 8'hF0, 8'h58});
        checkOutput("caps on", caps_lock, 1'b1);
        sendSeq('{8'h1C, 8'hF0, 8'h1C});
        checkGot("caps A", 1, 8'h41);
        sendSeq('{8'h12, 8'h1C, 8'h16});
        checkGot("shift caps", 2, 8'h61, 8'h21);
        checkOutput("mods shift caps", mods, 3'b011);
        sendSeq('{8'hF0, 8'h16, 8'hF0, 8'h1C, 8'hF0, 8'h12});
        checkOutput("mods caps only", mods, 3'b010);
        sendSeq('{8'h58, 8'h58, 8'h58, 8'hF0, 8'h58});
        checkOutput("caps typematic", caps_lock, 1'b0);

        doReset();
        sendSeq('{8'h14, 8'h21, 8'hF0, 8'h21, 8'hE0, 8'h14});
        checkOutput("mods both ctrl", mods, 3'b100);
        sendSeq('{8'h1C, 8'hF0, 8'h1C, 8'hE0, 8'hF0, 8'h14, 8'hF0, 8'h14});
        checkOutput("mods ctrl released", mods, 3'b000);
        sendSeq('{8'h1C, 8'hF0, 8'h1C});
        checkGot("ctrl", 3, 8'h03, 8'h01, 8'h61);

        sendSeq('{8'hE0, 8'h5A, 8'hE0, 8'hF0, 8'h5A, 8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75});
        checkGot("extended", 1, 8'h0A);
        sendSeq('{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77});
        checkOutput("pause mods", mods, 3'b000);
        sendSeq('{8'h1C, 8'hF0, 8'h1C});
        checkGot("pause", 1, 8'h61);

        doReset();
        @(posedge clk); #1 ascii_ready = 1'b0;
        sendSeq('{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B});
        checkOutput("full valid", ascii_valid, 1'b1);
        checkOutput("full head", ascii, 8'h61);
        checkOutput("full overflow", overflow, 1'b1);
        @(posedge clk); #1 ascii_ready = 1'b1;
        for (int c = 0; c < 50; c++) begin
            if (!ascii_valid) break;
            @(posedge clk); #1;
        end
        checkGot("backpressure", 4, 8'h61, 8'h62, 8'h63, 8'h64);
        checkOutput("drained valid", ascii_valid, 1'b0);
        checkOutput("overflow sticky", overflow, 1'b1);

        @(posedge clk); #1 ascii_ready = 1'b0;
        applyStimulus(8'h1C);
        applyStimulus(8'hE0);
        @(negedge clk); rst = 1'b1;
        #1;
        checkOutput("midreset valid", ascii_valid, 1'b0);
        checkOutput("midreset overflow", overflow, 1'b0);
        @(posedge clk); #1 rst = 1'b0; ascii_ready = 1'b1;
        modelReset(); gotQ.delete(); expQ.delete();
        applyStimulus(8'h5A);
        checkGot("reset after E0", 1, 8'h0A);

        doReset();
        randReady = 1'b1;
        for (int k = 0; k < 160; k++) begin
            r = $urandom_range(0, 19);
            if (r < 3) begin
                m = $urandom_range(0, 4);
                case (m)
                    0:       code = 8'h12;
                    1:       code = 8'h59;
                    4:       code = 8'h58;
                    default: code = 8'h14;
                endcase
                if (m == 3) applyStimulus(8'hE0);
                if ($urandom_range(0, 1) == 0) applyStimulus(8'hF0);
                applyStimulus(code);
            end else if (r < 6) begin
                n = $urandom_range(0, 5);
                code = (n == 0) ? 8'h4A : (n == 1) ? 8'h5A : (n == 2) ? 8'h71 :
                       (n == 3) ? 8'h75 : (n == 4) ? 8'h6B : 8'h7D;
                applyStimulus(8'hE0); applyStimulus(code);
                if ($urandom_range(0, 1) == 0) sendSeq('{8'hE0, 8'hF0, code});
            end else if (r == 6) begin
                sendSeq('{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77});
            end else begin
                code = poolQ[$urandom_range(0, poolQ.size() - 1)];
                applyStimulus(code);
                if ($urandom_range(0, 3) != 0) begin
                    applyStimulus(8'hF0); applyStimulus(code);
                end
            end
        end
        randReady = 1'b0;
        @(posedge clk); #1 ascii_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        checkOutput("random count", gotQ.size(), expQ.size());
        foreach (expQ[i])
            checkOutput($sformatf("random char%0d", i),
                        (i < gotQ.size()) ? {24'h0, gotQ[i]} : 32'hFFFF_FFFF, {24'h0, expQ[i]});
        checkOutput("random mods", mods, {mLc | mRc, mCaps, mL | mR});
        checkOutput("random caps", caps_lock, mCaps);
        checkOutput("random overflow", overflow, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
- Parametrised successor to the keyboard scan-code translator. Turns PS/2 set-2 scan bytes into ASCII characters.
- Adds over the single-register translator:
  - a prefix state machine (E0, F0, E1 pause sequence);
  - Ctrl and Caps Lock handling;
  - an output FIFO with a valid/ready handshake;
  - overflow reporting.
- Sits between the PS/2 receiver (scan/scanrdy) and the terminal character consumer.

Parameters:
- FIFO_DEPTH, 4: output FIFO entries. Must be a power of 2, at least 2.
- ENABLE_CTRL, 1: when 1, Ctrl+letter emits a control code. When 0, Ctrl is ignored.
- ENABLE_CAPS, 1: when 1, Caps Lock toggles the letter case. When 0, the 0x58 make code is ignored.
- UNKNOWN_CHAR, 8'h2E: emitted for an unmapped non-extended make code.

Ports:
- clk, input, 1: clock.
- rst, input, 1: reset, asynchronous, active-high.
- scan, input, 8: scan byte from the PS/2 receiver. Stable while scanrdy is high and for 2 clk after its fall.
- scanrdy, input, 1: byte strobe from the receiver. Its falling edge marks a new byte.
- ascii, output, 8: FIFO head character.
- ascii_valid, output, 1: FIFO is non-empty.
- ascii_ready, input, 1: consumer accepts the head entry.
- overflow, output, 1: sticky. Set when a character is dropped on a full FIFO.
- caps_lock, output, 1: current Caps Lock state, for the keyboard LED path.
- mods, output, 3: {ctrl, caps_lock, shift} live modifier state.

Behaviour:
- Reset (async, rst=1):
  - All registers clear; FIFO empty.
  - Outputs: ascii=0, ascii_valid=0, overflow=0, caps_lock=0, mods=0; state=IDLE.
- Edge detect:
  - history[1:0] <= {history[0], scanrdy} on every clk.
  - A byte event occurs on the clk where history==2'b10. scan is consumed at that edge.
- Decode FSM:
  - States: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0,F0 seen), PAUSE.
  - IDLE:
    - E0 -> EXT; F0 -> BRK; E1 -> PAUSE with skip counter = 7.
    - Any other byte is a make code: decode it, stay in IDLE.
  - EXT: F0 -> EXT_BRK; other byte = extended make, decode it -> IDLE.
  - BRK: non-extended break -> IDLE. Only modifier releases take effect; no output.
  - EXT_BRK: extended break -> IDLE. Only modifier releases take effect.
  - PAUSE: each byte event decrements the counter. At 0 -> IDLE. No output.
  - A repeated E0 while in EXT stays in EXT. F0 while in BRK stays in BRK.
- Modifiers:
  - lshift = 12, rshift = 59, lctrl = 14, rctrl = E0 14. Set on make, clear on break.
  - shift = lshift|rshift; ctrl = lctrl|rctrl.
  - Caps (58) toggles on make only when not already held. A caps_held flag is set on make and cleared on break, so typematic repeat does not re-toggle.
  - Modifier makes produce no output.
- Translation (make codes only):
  - Letters:
    - Base code is lower case (1C -> 0x61 'a', ..., 1A -> 0x7A 'z').
    - Upper case when shift XOR caps_lock.
    - If ctrl and ENABLE_CTRL: output is the letter & 0x1F. Case and shift are ignored.
  - Digits and punctuation: US layout, shifted variant when shift. Caps does not apply.
  - 66 -> 0x7F; 0D -> 0x09; 29 -> 0x20; 5A -> 0x0A; 76 -> 0x1B.
  - Keypad 70..7D -> digits and * - + as on the US layout.
  - Extended codes:
    - E0 4A -> 0x2F; E0 5A -> 0x0A; E0 71 -> 0x7F.
    - All other extended codes are dropped, with no output.
  - Unmapped non-extended make -> UNKNOWN_CHAR.
- FIFO:
  - Push on the byte-event clk when translation produces a char. ascii_valid rises on that same edge if the FIFO was empty.
  - Latency: 2 clk from the first clk sampling scanrdy=0 to ascii_valid=1.
  - Pop when ascii_valid & ascii_ready.
  - Push while full with a simultaneous pop: both happen, count unchanged.
  - Push while full without a pop: char dropped, overflow <= 1 until reset.
  - Pointers wrap modulo FIFO_DEPTH. Count width is clog2(FIFO_DEPTH)+1.
  - ascii holds the head entry; its value is don't-care while empty.
- Reset mid-sequence (e.g. after E0 or during PAUSE) returns to IDLE and empties the FIFO.

Decomposition:
- Package ps2_key_pkg:
  - FSM state enum.
  - Scan constants: SC_EXT=E0, SC_BRK=F0, SC_PAUSE=E1, SC_LSHIFT, SC_RSHIFT, SC_CTRL, SC_CAPS.
  - PAUSE_SKIP=7.
  - A translation function taking {ext, scan, shift, caps, ctrl} and returning {hit, char}.
- Sub-module char_fifo: parametrised by depth and width, with push/pop/full/empty. It is reusable by the terminal transmit path.

Test Plan:
- Single key: bytes 1C, F0, 1C -> exactly one char 0x61 'a'. ascii_valid rises 2 clk after the first clk sampling scanrdy=0.
- Shift and Caps:
  - 12, 1C, F0 1C, F0 12 -> 0x41 'A'.
  - 58, F0 58, then 1C -> 0x41.
  - Then 12, 1C -> 0x61.
  - Then 16 with shift held -> 0x21 '!'.
  - caps_lock=1 throughout, after the first 58.
- Ctrl: 14, 21 -> 0x03. E0 14 (rctrl), 1C -> 0x01. After E0 F0 14 and F0 14, 1C -> 0x61.
- Extended and pause:
  - E0 5A -> 0x0A. E0 75 (up arrow) -> no output.
  - E1 14 77 E1 F0 14 F0 77, then 1C -> only 0x61.
- Backpressure: ascii_ready=0, 6 keys with FIFO_DEPTH=4 -> first 4 chars retained in order, overflow=1. Release ready -> 4 pops, then ascii_valid=0.
- Reset after E0 and before the next byte, then byte 5A -> 0x0A (not an extended decode). FIFO empty and overflow=0 immediately on rst.
